// File: rtl/cu_pkg.sv
// cu_pkg: shared state encoding, opcode, register-select and ALU constants for control_unit
package cu_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC1, S_EXEC2, S_HALT
  } state_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] SEL_L = 3'b111;
  localparam logic [2:0] SEL_W = 3'b010;
  localparam logic [2:0] SEL_K = 3'b011;
  localparam logic [2:0] SEL_T = 3'b001;
  localparam logic [2:0] SEL_X = 3'b101;
  localparam logic [2:0] SEL_J = 3'b110;
  // ALU result register shares the J mux slot
  localparam logic [2:0] SEL_ALU = 3'b110;
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  function automatic logic op_defined(input logic [3:0] op);
    return op <= OP_JZ || op == OP_HALT;
  endfunction
endpackage

// File: rtl/cu_dst_decoder.sv
// cu_dst_decoder: 3-bit register select plus enable to one-hot {J,X,T,K,W,L} write enables
module cu_dst_decoder
  import cu_pkg::*;
(
  input  logic [2:0] code,
  input  logic       en,
  output logic [5:0] wr_en
);
  assign wr_en = en ? {code == SEL_J, code == SEL_X, code == SEL_T,
                       code == SEL_K, code == SEL_W, code == SEL_L} : 6'b0;
endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 24-bit datapath.
// Define CU_ILLEGAL_TRAP_EN to halt with a sticky illegal flag on undefined opcodes.
module control_unit
  import cu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [11:0]      instr_in,
  input  logic             z_flag,
  output logic [2:0]       mux_sel,
  output logic [5:0]       wr_en,
  output logic [1:0]       alu_op,
  output logic             alu_en,
  output logic             mem_rd,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             busy,
  output logic             halt,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  state_t           state_q, state_d;
  logic [11:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op;
  logic [2:0]       dst, src;
  logic             undef, arith, trap, retire, uses_src, wr_go, e1, e2, dec;
  logic             unused_ir;
  assign op        = ir_q[11:8];
  assign dst       = ir_q[5:3];
  assign src       = ir_q[2:0];
  assign unused_ir = ^ir_q[7:6];
  assign undef     = !op_defined(op);
  assign arith     = op == OP_ADD || op == OP_SUB;
  assign dec       = state_q == S_DECODE;
  assign e1        = state_q == S_EXEC1;
  assign e2        = state_q == S_EXEC2;
`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign trap      = undef;
  assign illegal_d = illegal_q | (dec && undef);
  assign illegal   = illegal_q;
`else
  assign trap    = 1'b0;
  assign illegal = dec && undef;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_FETCH1 : S_IDLE;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: state_d = (op == OP_HALT || trap) ? S_HALT : S_EXEC1;
      S_EXEC1:  state_d = arith ? S_EXEC2 : S_FETCH1;
      S_EXEC2:  state_d = S_FETCH1;
      default:  state_d = state_q;
    endcase
    ir_d   = state_q == S_FETCH2 ? instr_in : ir_q;
    retire = (dec && op == OP_HALT) || (e1 && !arith) || e2;
    cnt_d  = (retire && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end
  assign uses_src    = e1 && (op == OP_MOV || arith || op == OP_JMP || op == OP_JZ);
  assign wr_go       = (e1 && op == OP_MOV) || e2;
  assign mux_sel     = e2 ? SEL_ALU : uses_src ? src : SEL_L;
  assign alu_op      = (e1 && op == OP_ADD) ? ALU_ADD : (e1 && op == OP_SUB) ? ALU_SUB : ALU_PASS;
  assign alu_en      = e1 && arith;
  assign mem_rd      = state_q == S_FETCH1;
  assign pc_inc      = state_q == S_FETCH2;
  assign pc_load     = e1 && (op == OP_JMP || (op == OP_JZ && z_flag));
  assign busy        = state_q != S_IDLE && state_q != S_HALT;
  assign halt        = state_q == S_HALT;
  assign instr_count = cnt_q;
  cu_dst_decoder u_dst (
    .code  (dst),
    .en    (wr_go),
    .wr_en (wr_en)
  );
endmodule
